// File: rtl/tx_intf_s_axis.sv
// rtl/tx_intf_s_axis.sv - AXI-Stream slave feeding a single-clock FIFO toward the TX accelerator
// Counts beats per armed transaction and checks TLAST against the programmed beat count.
module tx_intf_s_axis #(
    parameter int MAX_NUM_DMA_SYMBOL     = 8192,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int FIFO_ADDR_BITS         = 9,
    parameter int C_S_AXIS_TDATA_WIDTH   = 64
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESETN,
    input  logic                                endless_mode,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   S_AXIS_NUM_DMA_SYMBOL,
    input  logic                                start_1trans,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                ACC_ASK_DATA,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     DATA_TO_ACC,
    output logic                                EMPTYN_TO_ACC,
    output logic [FIFO_ADDR_BITS:0]             data_count,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   beat_count,
    output logic                                trans_done,
    output logic                                tlast_err
);
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int CW    = MAX_BIT_NUM_DMA_SYMBOL;
    localparam int DW    = C_S_AXIS_TDATA_WIDTH;

    if (MAX_NUM_DMA_SYMBOL > (1 << MAX_BIT_NUM_DMA_SYMBOL)) begin : g_bad_cfg
        $error("beat counter too narrow for MAX_NUM_DMA_SYMBOL");
    end

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       start_q;
    logic [CW-1:0]              beat_count_q, beat_count_d;
    logic                       tlast_err_q, tlast_err_d;
    logic [FIFO_ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]    count_q, count_d;
    logic [DW-1:0]              rd_data_q, rd_data_d;
    logic [DW-1:0]              fifo_mem [DEPTH];

    logic                       start_pulse, full, tready, wr_en, rd_en;
    logic [CW-1:0]              base_count;
    logic                       unused_tstrb;

    assign unused_tstrb = ^S_AXIS_TSTRB;
    assign start_pulse  = start_1trans && !start_q;
    // occupancy never exceeds DEPTH, so the MSB alone marks full
    assign full         = count_q[FIFO_ADDR_BITS];
    assign wr_en        = S_AXIS_TVALID && tready;
    assign rd_en        = ACC_ASK_DATA && (count_q != '0);

    always_comb begin
        state_d      = state_q;
        beat_count_d = beat_count_q;
        tlast_err_d  = tlast_err_q;
        tready       = 1'b0;
        // a restart in RECV makes a same-cycle beat the first of the new transaction
        base_count   = start_pulse ? '0 : beat_count_q;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d      = RECV;
                    beat_count_d = '0;
                    tlast_err_d  = 1'b0;
                end
            end
            RECV: begin
                tready = !full && ((beat_count_q <= S_AXIS_NUM_DMA_SYMBOL) || endless_mode);
                if (start_pulse) begin
                    beat_count_d = '0;
                    tlast_err_d  = 1'b0;
                end
                if (S_AXIS_TVALID && tready) begin
                    beat_count_d = base_count + CW'(1);
                    if (!endless_mode) begin
                        if (base_count == S_AXIS_NUM_DMA_SYMBOL) begin
                            state_d = DONE;
                            if (!S_AXIS_TLAST) tlast_err_d = 1'b1;
                        end else if (S_AXIS_TLAST) begin
                            state_d     = DONE;
                            tlast_err_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = start_pulse ? RECV : IDLE;
                if (start_pulse) begin
                    beat_count_d = '0;
                    tlast_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data_d = rd_en ? fifo_mem[rd_ptr_q] : rd_data_q;
        count_d   = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            beat_count_q <= '0;
            tlast_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_1trans;
            beat_count_q <= beat_count_d;
            tlast_err_q  <= tlast_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= S_AXIS_TDATA;
    end

    assign S_AXIS_TREADY = tready;
    assign DATA_TO_ACC   = rd_data_q;
    assign EMPTYN_TO_ACC = (count_q != '0);
    assign data_count    = count_q;
    assign beat_count    = beat_count_q;
    assign trans_done    = (state_q == DONE);
    assign tlast_err     = tlast_err_q;
endmodule

// File: tb/tb_tx_intf_s_axis.sv
// tb/tb_tx_intf_s_axis.sv - randomized self-checking bench for tx_intf_s_axis
module tb_tx_intf_s_axis;
    localparam int AB = 4;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0, rst_n = 1'b0;
    logic endless = 1'b0, start = 1'b0, tvalid = 1'b0, tlast = 1'b0, ask = 1'b0;
    logic [13:0] num = '0;
    logic [63:0] tdata = '0;
    logic [7:0]  tstrb = 8'hff;
    logic        tready, emptyn, trans_done, tlast_err;
    logic [63:0] data_to_acc;
    logic [AB:0] data_count;
    logic [13:0] beat_count;

    int tests_run = 0, tests_failed = 0;
    int rdy_mis, dat_mis, st_mis, done_seen, accepts;

    int           m_phase, m_cnt;
    logic         m_err, m_start_prev;
    logic [63:0]  m_data;
    logic [63:0]  m_q[$];

    always #5 clk = ~clk;

    tx_intf_s_axis #(.FIFO_ADDR_BITS(AB)) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .endless_mode(endless),
        .S_AXIS_NUM_DMA_SYMBOL(num), .start_1trans(start), .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready), .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb),
        .S_AXIS_TLAST(tlast), .ACC_ASK_DATA(ask), .DATA_TO_ACC(data_to_acc),
        .EMPTYN_TO_ACC(emptyn), .data_count(data_count), .beat_count(beat_count),
        .trans_done(trans_done), .tlast_err(tlast_err)
    );

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_err = 1'b0; m_start_prev = 1'b0;
        m_data = '0; m_q.delete();
        rdy_mis = 0; dat_mis = 0; st_mis = 0; done_seen = 0; accepts = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 0; tvalid = 0; tlast = 0; ask = 0; endless = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    // one clock: drive, compare against the reference at negedge, advance the reference at posedge
    task automatic cycle(input logic v, input logic [63:0] d, input logic l, input logic a,
                         input logic st, output logic acc_o, output logic rdy_o);
        logic sp, exp_rdy, acc, rd;
        int base;
        tvalid = v; tdata = d; tlast = l; ask = a; start = st;
        @(negedge clk);
        sp = st && !m_start_prev;
        exp_rdy = (m_phase == 1) && (m_q.size() < DEPTH) && ((m_cnt <= int'(num)) || endless);
        if (tready !== exp_rdy) rdy_mis++;
        if (data_to_acc !== m_data || emptyn !== (m_q.size() != 0) || data_count !== m_q.size()) dat_mis++;
        if (beat_count !== m_cnt[13:0] || tlast_err !== m_err || trans_done !== (m_phase == 2)) st_mis++;
        if (trans_done === 1'b1) done_seen++;
        acc = v && exp_rdy;
        rd = a && (m_q.size() != 0);
        rdy_o = tready; acc_o = acc;
        if (acc) accepts++;
        @(posedge clk);
        base = sp ? 0 : m_cnt;
        if (rd) m_data = m_q.pop_front();
        if (acc) m_q.push_back(d);
        case (m_phase)
            0: if (sp) begin m_phase = 1; m_cnt = 0; m_err = 1'b0; end
            1: begin
                if (sp) begin m_cnt = 0; m_err = 1'b0; end
                if (acc) begin
                    m_cnt = (base + 1) % 16384;
                    if (!endless && (base == int'(num) || l)) begin
                        m_phase = 2;
                        m_err = m_err | (base != int'(num)) | !l;
                    end
                end
            end
            default: begin
                m_phase = sp ? 1 : 0;
                if (sp) begin m_cnt = 0; m_err = 1'b0; end
            end
        endcase
        m_start_prev = st;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        tests_run++;
        if ({tready, emptyn, trans_done, tlast_err} !== 4'b0 || data_count !== '0 ||
            beat_count !== '0 || data_to_acc !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rdy=%b ne=%b done=%b err=%b cnt=%0d bc=%0d data=%h, required all 0",
                     tready, emptyn, trans_done, tlast_err, data_count, beat_count, data_to_acc);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [63:0] beats [4];
        logic acc, rdy;
        int idx = 0, rdy_hi = 0;
        beats[0] = 64'h11; beats[1] = 64'h22; beats[2] = 64'h33; beats[3] = 64'h44;
        do_reset(); num = 14'd3;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, beats[idx], idx == 3, 1'b0, c == 0, acc, rdy);
            if (rdy) rdy_hi++;
            if (acc && idx < 3) idx++;
        end
        tests_run++;
        if (rdy_hi !== 4 || done_seen !== 1) begin tests_failed++;
            $display("FAIL basic_handshake: tready_cycles=%0d done=%0d, required 4 and 1", rdy_hi, done_seen); end
        tests_run++;
        if (beat_count !== 14'd4 || tlast_err !== 1'b0) begin tests_failed++;
            $display("FAIL basic_status: beat_count=%0d err=%b, required 4 and 0", beat_count, tlast_err); end
        for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc, rdy);
        tests_run++;
        if (data_to_acc !== 64'h44 || emptyn !== 1'b0) begin tests_failed++;
            $display("FAIL basic_drain: data=%h emptyn=%b, required 44 and 0", data_to_acc, emptyn); end
        tests_run++;
        if ({rdy_mis, dat_mis, st_mis} !== '0) begin tests_failed++;
            $display("FAIL basic_cycle: rdy/data/state mismatches %0d/%0d/%0d, required 0", rdy_mis, dat_mis, st_mis); end
    endtask

    task automatic test_early_tlast();
        logic acc, rdy, v;
        int n = 0, c = 0;
        do_reset(); num = 14'd7;
        while (done_seen == 0 && c < 60) begin
            v = ($urandom_range(0, 3) != 0);
            cycle(v, {$urandom, $urandom}, n == 2, $urandom_range(0, 1), c == 0, acc, rdy);
            if (acc) n++;
            c++;
        end
        tests_run++;
        if (done_seen !== 1) begin tests_failed++;
            $display("FAIL early_done: done pulses=%0d within %0d cycles, required 1", done_seen, c); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc, rdy);
        tests_run++;
        if (beat_count !== 14'd3 || tlast_err !== 1'b1) begin tests_failed++;
            $display("FAIL early_status: beat_count=%0d err=%b, required 3 and 1", beat_count, tlast_err); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc, rdy);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc, rdy);
        tests_run++;
        if (tlast_err !== 1'b0 || {rdy_mis, dat_mis, st_mis} !== '0) begin tests_failed++;
            $display("FAIL early_restart: err=%b mismatches %0d/%0d/%0d, required 0", tlast_err, rdy_mis, dat_mis, st_mis); end
    endtask

    task automatic test_no_tlast();
        logic acc, rdy;
        do_reset(); num = 14'd3;
        for (int c = 0; c < 10; c++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, c == 0, acc, rdy);
        tests_run++;
        if (accepts !== 4 || done_seen !== 1 || tlast_err !== 1'b1 || tready !== 1'b0) begin tests_failed++;
            $display("FAIL missing_tlast: accepts=%0d done=%0d err=%b tready=%b, required 4 1 1 0",
                     accepts, done_seen, tlast_err, tready); end
        tests_run++;
        if ({rdy_mis, dat_mis, st_mis} !== '0) begin tests_failed++;
            $display("FAIL missing_tlast_cycle: mismatches %0d/%0d/%0d, required 0", rdy_mis, dat_mis, st_mis); end
    endtask

    task automatic test_full();
        logic acc, rdy;
        do_reset(); num = 14'd31;
        for (int c = 0; c < 24; c++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, c == 0, acc, rdy);
        tests_run++;
        if (data_count !== 5'd16 || tready !== 1'b0 || accepts !== 16) begin tests_failed++;
            $display("FAIL full_stall: count=%0d tready=%b accepts=%0d, required 16 0 16", data_count, tready, accepts); end
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, acc, rdy);
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, acc, rdy);
        tests_run++;
        if (rdy !== 1'b1 || accepts !== 17 || data_count !== 5'd16) begin tests_failed++;
            $display("FAIL full_resume: tready=%b accepts=%0d count=%0d, required 1 17 16", rdy, accepts, data_count); end
        for (int c = 0; c < 120; c++)
            cycle($urandom_range(0, 1), {$urandom, $urandom}, accepts == 31, $urandom_range(0, 1), 1'b0, acc, rdy);
        tests_run++;
        if (done_seen !== 1 || tlast_err !== 1'b0 || {rdy_mis, dat_mis, st_mis} !== '0) begin tests_failed++;
            $display("FAIL full_cycle: done=%0d err=%b mismatches %0d/%0d/%0d, required 1 0 0", done_seen, tlast_err,
                     rdy_mis, dat_mis, st_mis); end
    endtask

    task automatic test_endless();
        logic acc, rdy;
        int c = 0;
        do_reset(); endless = 1'b1; num = 14'($urandom_range(0, 100));
        while (accepts < 70000 && c < 72000) begin
            cycle(1'b1, {$urandom, $urandom}, $urandom_range(0, 1), 1'b1, c == 0, acc, rdy);
            c++;
        end
        tests_run++;
        if (accepts !== 70000 || done_seen !== 0 || beat_count !== 14'(70000 % 16384)) begin tests_failed++;
            $display("FAIL endless_wrap: accepts=%0d done=%0d beat_count=%0d, required 70000 0 %0d",
                     accepts, done_seen, beat_count, 70000 % 16384); end
        tests_run++;
        if ({rdy_mis, dat_mis, st_mis} !== '0) begin tests_failed++;
            $display("FAIL endless_cycle: mismatches %0d/%0d/%0d, required 0", rdy_mis, dat_mis, st_mis); end
    endtask

    task automatic test_reset_mid();
        logic acc, rdy;
        do_reset(); num = 14'd20;
        for (int c = 0; c < 7; c++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, c == 0, acc, rdy);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc, rdy);
        tests_run++;
        if (data_count !== 5'd5 || data_to_acc === 64'h0 || {rdy_mis, dat_mis, st_mis} !== '0) begin tests_failed++;
            $display("FAIL mid_prefill: count=%0d data=%h mismatches %0d/%0d/%0d, required 5 nonzero 0",
                     data_count, data_to_acc, rdy_mis, dat_mis, st_mis); end
        tvalid = 1'b1;
        #2 rst_n = 1'b0; #1;
        tests_run++;
        if ({tready, emptyn, trans_done, tlast_err} !== 4'b0 || data_count !== '0 ||
            beat_count !== '0 || data_to_acc !== '0) begin tests_failed++;
            $display("FAIL mid_async_reset: rdy=%b ne=%b done=%b err=%b cnt=%0d bc=%0d data=%h, required all 0",
                     tready, emptyn, trans_done, tlast_err, data_count, beat_count, data_to_acc); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        for (int c = 0; c < 6; c++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, acc, rdy);
        tests_run++;
        if (accepts !== 0 || done_seen !== 0 || {rdy_mis, dat_mis, st_mis} !== '0) begin tests_failed++;
            $display("FAIL mid_after_release: accepts=%0d done=%0d mismatches %0d/%0d/%0d, required 0",
                     accepts, done_seen, rdy_mis, dat_mis, st_mis); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_early_tlast();
        test_no_tlast();
        test_full();
        test_endless();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
